// File: rtl/shadow_ray_gen_multi.sv
// Shadow ray generator for directional lights.
// Buffers raster records in a small FIFO and, for every hit record, emits one
// shadow-ray record per light carrying the light direction and its
// component-wise fixed-point reciprocal. A miss record emits one zeroed record.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   in_valid/in_ready               - input handshake (in_ready = FIFO not full)
//   in_hit, in_payload              - raster record stored in the FIFO
//   light_dir                       - NUM_LIGHTS x {z,y,x} directions, light 0 in LSBs
//   out_valid/out_ready             - output handshake
//   out_hit, out_payload            - copy of the record being expanded
//   out_light_idx, out_dir          - light index and direction of this shadow ray
//   out_inv_dir                     - reciprocal of out_dir, FRAC_W fractional bits
//   out_last                        - final output record of the input record
module shadow_ray_gen_multi #(
    parameter int unsigned PAYLOAD_W  = 256,
    parameter int unsigned COMP_W     = 16,
    parameter int unsigned FRAC_W     = 8,
    parameter int unsigned NUM_LIGHTS = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic                                                in_hit,
    input  logic [PAYLOAD_W-1:0]                                in_payload,
    input  logic [NUM_LIGHTS*3*COMP_W-1:0]                      light_dir,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic                                                out_hit,
    output logic [PAYLOAD_W-1:0]                                out_payload,
    output logic [((NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1)-1:0] out_light_idx,
    output logic [3*COMP_W-1:0]                                 out_dir,
    output logic [3*COMP_W-1:0]                                 out_inv_dir,
    output logic                                                out_last
);

    localparam int unsigned Q_W    = 2 * FRAC_W + 1;
    localparam int unsigned DIR_W  = 3 * COMP_W;
    localparam int unsigned IDX_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = PAYLOAD_W + 1;
    localparam int unsigned QX_W   = (Q_W > COMP_W) ? Q_W : COMP_W;
    localparam int unsigned DCNT_W = $clog2(Q_W);

    localparam logic [COMP_W-1:0] SAT_MAG  = {1'b0, {(COMP_W-1){1'b1}}};
    localparam logic [QX_W-1:0]   SAT_MAX  = QX_W'(SAT_MAG);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LIGHTS - 1);
    localparam logic [DCNT_W-1:0] DIV_LAST = DCNT_W'(Q_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_EMIT} state_t;

    state_t state_q, state_nxt;

    // ---------------------------------------------------------------- FIFO
    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_nxt;
    logic             push_c, pop_c;
    logic             head_hit;
    logic [PAYLOAD_W-1:0] head_payload;

    assign push_c       = in_valid && in_ready;
    assign head_hit     = mem[rd_ptr_q][PAYLOAD_W];
    assign head_payload = mem[rd_ptr_q][PAYLOAD_W-1:0];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_nxt = count_q;
        if (push_c && !pop_c) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (!push_c && pop_c) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Pointers, occupancy and registered ready (a pop while full frees a slot next cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            in_ready <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q  <= count_nxt;
            in_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // Storage array, no reset needed: occupancy tracking guards reads.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr_q] <= {in_hit, in_payload};
    end

    // ------------------------------------------------------------ FSM / ctrl
    logic [IDX_W-1:0]  light_idx_q, start_idx;
    logic [DCNT_W-1:0] div_cnt_q;
    logic              div_start_c, div_last_c, emit_fire_c, advance_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (count_q != '0) state_nxt = head_hit ? S_DIV : S_EMIT;
            S_DIV:  if (div_cnt_q == DIV_LAST) state_nxt = S_EMIT;
            S_EMIT: if (out_ready) begin
                        state_nxt = (out_hit && (light_idx_q != LAST_IDX)) ? S_DIV : S_IDLE;
                    end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        pop_c       = 1'b0;
        div_start_c = 1'b0;
        div_last_c  = 1'b0;
        emit_fire_c = 1'b0;
        advance_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                pop_c       = (count_q != '0);
                div_start_c = (count_q != '0) && head_hit;
            end
            S_DIV: div_last_c = (div_cnt_q == DIV_LAST);
            S_EMIT: begin
                emit_fire_c = out_ready;
                advance_c   = out_ready && out_hit && (light_idx_q != LAST_IDX);
                div_start_c = advance_c;
            end
            default: ;
        endcase
    end

    // --------------------------------------------------------------- divider
    logic [DIR_W-1:0]  sel_dir, cur_dir_q, inv_c;
    logic [COMP_W-1:0] div_d_q   [3];
    logic [COMP_W-1:0] rem_q     [3];
    logic [Q_W-2:0]    quo_q     [3];
    logic [2:0]        div_neg_q;
    logic [COMP_W:0]   rem_sh    [3];
    logic [COMP_W-1:0] rem_nxt   [3];
    logic [Q_W-1:0]    quo_nxt   [3];
    logic [COMP_W-1:0] start_mag [3];
    logic [2:0]        start_neg, quo_bit;
    logic [COMP_W-1:0] comp, mag;
    logic [QX_W-1:0]   quo_ext;

    // Direction of the light about to be divided (first light on pop, next on advance).
    always_comb begin
        start_idx = (state_q == S_IDLE) ? '0 : light_idx_q + IDX_W'(1);
        sel_dir   = light_dir[int'(start_idx) * DIR_W +: DIR_W];
        comp      = '0;
        for (int k = 0; k < 3; k++) begin
            comp         = sel_dir[k*COMP_W +: COMP_W];
            start_neg[k] = comp[COMP_W-1];
            // Two's-complement negate; the most negative value maps to 2^(COMP_W-1).
            start_mag[k] = comp[COMP_W-1] ? (COMP_W'(0) - comp) : comp;
        end
    end

    // One restoring step per cycle on 2^(2*FRAC_W); the dividend's only set bit enters first.
    always_comb begin
        inv_c   = '0;
        quo_ext = '0;
        mag     = '0;
        for (int k = 0; k < 3; k++) begin
            rem_sh[k]  = {rem_q[k], (div_cnt_q == '0)};
            quo_bit[k] = (rem_sh[k] >= {1'b0, div_d_q[k]});
            rem_nxt[k] = quo_bit[k] ? COMP_W'(rem_sh[k] - {1'b0, div_d_q[k]})
                                    : rem_sh[k][COMP_W-1:0];
            quo_nxt[k] = {quo_q[k], quo_bit[k]};
            // Zero divisor yields all ones, which saturates to the positive maximum.
            quo_ext    = QX_W'(quo_nxt[k]);
            mag        = (quo_ext > SAT_MAX) ? SAT_MAG : quo_ext[COMP_W-1:0];
            inv_c[k*COMP_W +: COMP_W] = div_neg_q[k] ? (COMP_W'(0) - mag) : mag;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_hit       <= 1'b0;
            out_payload   <= '0;
            out_light_idx <= '0;
            out_dir       <= '0;
            out_inv_dir   <= '0;
            out_last      <= 1'b0;
            light_idx_q   <= '0;
            div_cnt_q     <= '0;
            cur_dir_q     <= '0;
            div_neg_q     <= '0;
            for (int k = 0; k < 3; k++) begin
                div_d_q[k] <= '0;
                rem_q[k]   <= '0;
                quo_q[k]   <= '0;
            end
        end else begin
            if (pop_c) begin
                out_hit     <= head_hit;
                out_payload <= head_payload;
                light_idx_q <= '0;
                if (!head_hit) begin
                    out_valid     <= 1'b1;
                    out_last      <= 1'b1;
                    out_light_idx <= '0;
                    out_dir       <= '0;
                    out_inv_dir   <= '0;
                end
            end
            if (div_start_c) begin
                div_cnt_q <= '0;
                cur_dir_q <= sel_dir;
                div_neg_q <= start_neg;
                for (int k = 0; k < 3; k++) begin
                    div_d_q[k] <= start_mag[k];
                    rem_q[k]   <= '0;
                    quo_q[k]   <= '0;
                end
            end else if (state_q == S_DIV) begin
                div_cnt_q <= div_cnt_q + DCNT_W'(1);
                for (int k = 0; k < 3; k++) begin
                    rem_q[k] <= rem_nxt[k];
                    quo_q[k] <= quo_nxt[k][Q_W-2:0];
                end
            end
            if (div_last_c) begin
                out_valid     <= 1'b1;
                out_dir       <= cur_dir_q;
                out_inv_dir   <= inv_c;
                out_light_idx <= light_idx_q;
                out_last      <= (light_idx_q == LAST_IDX);
            end
            if (emit_fire_c) out_valid <= 1'b0;
            if (advance_c)   light_idx_q <= light_idx_q + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_shadow_ray_gen_multi.sv
// Directed bench for shadow_ray_gen_multi: table of hand-computed vectors plus
// sequences for backpressure and mid-operation reset.
module tb_shadow_ray_gen_multi;

    localparam int unsigned PAYLOAD_W  = 256;
    localparam int unsigned COMP_W     = 16;
    localparam int unsigned FRAC_W     = 8;
    localparam int unsigned NUM_LIGHTS = 2;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned Q_W        = 2 * FRAC_W + 1;
    localparam int unsigned DIR_W      = 3 * COMP_W;
    localparam int unsigned LD_W       = NUM_LIGHTS * DIR_W;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_hit;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [LD_W-1:0]      light_dir;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_hit;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [0:0]           out_light_idx;
    logic [DIR_W-1:0]     out_dir;
    logic [DIR_W-1:0]     out_inv_dir;
    logic                 out_last;

    shadow_ray_gen_multi #(
        .PAYLOAD_W (PAYLOAD_W),
        .COMP_W    (COMP_W),
        .FRAC_W    (FRAC_W),
        .NUM_LIGHTS(NUM_LIGHTS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_hit       (in_hit),
        .in_payload   (in_payload),
        .light_dir    (light_dir),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_hit      (out_hit),
        .out_payload  (out_payload),
        .out_light_idx(out_light_idx),
        .out_dir      (out_dir),
        .out_inv_dir  (out_inv_dir),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                 hit;
        logic [PAYLOAD_W-1:0] payload;
        logic [LD_W-1:0]      ldir;
        logic [DIR_W-1:0]     inv0;
        logic [DIR_W-1:0]     inv1;
    } vec_t;

    typedef struct {
        logic                 hit;
        logic [PAYLOAD_W-1:0] payload;
        logic                 idx;
        logic [DIR_W-1:0]     dir;
        logic [DIR_W-1:0]     inv;
        logic                 last;
    } exp_t;

    vec_t tbl [3];
    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [PAYLOAD_W-1:0] act,
                       input logic [PAYLOAD_W-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input exp_t e, input string tag);
        chk({tag, ".valid"},   out_valid,     1);
        chk({tag, ".hit"},     out_hit,       e.hit);
        chk({tag, ".payload"}, out_payload,   e.payload);
        chk({tag, ".idx"},     out_light_idx, e.idx);
        chk({tag, ".dir"},     out_dir,       e.dir);
        chk({tag, ".inv"},     out_inv_dir,   e.inv);
        chk({tag, ".last"},    out_last,      e.last);
    endtask

    // Caller has just ticked once; lat counts cycles since the triggering edge's cycle.
    task automatic wait_valid(output int lat, input int budget);
        lat = 1;
        while (!out_valid && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    task automatic push(input logic hit, input logic [PAYLOAD_W-1:0] p);
        in_hit     = hit;
        in_payload = p;
        in_valid   = 1'b1;
        chk("push.in_ready", in_ready, 1);
        tick();
        in_valid   = 1'b0;
    endtask

    function automatic exp_t make_exp(input vec_t v, input int l);
        exp_t e;
        e.hit     = v.hit;
        e.payload = v.payload;
        e.idx     = v.hit ? 1'(l) : 1'b0;
        e.dir     = v.hit ? v.ldir[l*DIR_W +: DIR_W] : '0;
        e.inv     = !v.hit ? '0 : ((l == 0) ? v.inv0 : v.inv1);
        e.last    = !v.hit || (l == NUM_LIGHTS - 1);
        return e;
    endfunction

    // Push one record into an idle block with out_ready=1 and check every output.
    task automatic run_vec(input int i, input string tag);
        int lat;
        int nout;
        nout      = tbl[i].hit ? NUM_LIGHTS : 1;
        light_dir = tbl[i].ldir;
        out_ready = 1'b1;
        push(tbl[i].hit, tbl[i].payload);
        wait_valid(lat, 100);
        chk({tag, ".latency"}, 256'(lat), tbl[i].hit ? 256'(Q_W + 2) : 256'd2);
        for (int l = 0; l < nout; l++) begin
            if (l > 0) begin
                wait_valid(lat, 100);
                chk({tag, ".gap"}, 256'(lat), 256'(Q_W + 1));
            end
            check_out(make_exp(tbl[i], l), tag);
            tick();
        end
        chk({tag, ".idle_valid"}, out_valid, 0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".in_ready"}, in_ready,      0);
        chk({tag, ".valid"},    out_valid,     0);
        chk({tag, ".last"},     out_last,      0);
        chk({tag, ".hit"},      out_hit,       0);
        chk({tag, ".idx"},      out_light_idx, 0);
        chk({tag, ".dir"},      out_dir,       0);
        chk({tag, ".inv"},      out_inv_dir,   0);
        chk({tag, ".payload"},  out_payload,   0);
    endtask

    initial begin
        int lat;
        int idx_in;
        int seen;
        logic acc;
        exp_t e;

        // Light packing {light1 {z,y,x}, light0 {z,y,x}}; inverses hand-computed.
        tbl[0].hit     = 1'b1;
        tbl[0].payload = 256'hA5A5_0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_0001;
        tbl[0].ldir    = {16'h8000, 16'h0001, 16'hFF80, 16'h0000, 16'h0100, 16'h0200};
        tbl[0].inv0    = {16'h7FFF, 16'h0100, 16'h0080};
        tbl[0].inv1    = {16'hFFFE, 16'h7FFF, 16'hFE00};

        tbl[1].hit     = 1'b1;
        tbl[1].payload = 256'hDEAD_BEEF_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_CAFE_0002;
        tbl[1].ldir    = {16'h0002, 16'hFFFF, 16'h7FFF, 16'h0300, 16'hFF00, 16'h0080};
        tbl[1].inv0    = {16'h0055, 16'hFF00, 16'h0200};
        tbl[1].inv1    = {16'h7FFF, 16'h8001, 16'h0002};

        tbl[2].hit     = 1'b0;
        tbl[2].payload = 256'h1234_5678_9ABC_DEF0_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0003;
        tbl[2].ldir    = tbl[0].ldir;
        tbl[2].inv0    = '0;
        tbl[2].inv1    = '0;

        reset      = 1'b1;
        in_valid   = 1'b0;
        in_hit     = 1'b0;
        in_payload = '0;
        light_dir  = '0;
        out_ready  = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();
        chk("post_reset.in_ready", in_ready, 1);

        // Table-driven vectors.
        for (int i = 0; i < 3; i++) run_vec(i, $sformatf("vec%0d", i));

        // Backpressure: six records offered while out_ready is held low.
        light_dir = tbl[0].ldir;
        out_ready = 1'b0;
        for (int j = 0; j < 6; j++) begin
            vec_t v;
            v         = tbl[0];
            v.hit     = (j % 2 == 0);
            v.payload = 256'hB000 + 256'(j);
            for (int l = 0; l < (v.hit ? NUM_LIGHTS : 1); l++) exp_q.push_back(make_exp(v, l));
        end
        idx_in = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid   = (idx_in < 6);
            in_hit     = (idx_in % 2 == 0);
            in_payload = 256'hB000 + 256'(idx_in);
            acc        = in_valid && in_ready;
            tick();
            if (acc) idx_in++;
        end
        chk("bp.accepted", 256'(idx_in), 256'd5);
        chk("bp.in_ready", in_ready, 0);
        check_out(exp_q[0], "bp.stall");
        out_ready = 1'b1;
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            in_valid   = (idx_in < 6);
            in_hit     = (idx_in % 2 == 0);
            in_payload = 256'hB000 + 256'(idx_in);
            acc        = in_valid && in_ready;
            if (out_valid) begin
                e = exp_q.pop_front();
                check_out(e, "bp.drain");
            end
            tick();
            if (acc) idx_in++;
        end
        in_valid = 1'b0;
        chk("bp.all_out", 256'(exp_q.size()), 256'd0);
        chk("bp.all_in",  256'(idx_in), 256'd6);
        exp_q.delete();
        tick();
        chk("bp.idle_valid", out_valid, 0);

        // Reset during DIV with a buffered burst.
        light_dir = tbl[0].ldir;
        out_ready = 1'b1;
        push(1'b1, 256'hC001);
        push(1'b1, 256'hC002);
        push(1'b0, 256'hC003);
        for (int c = 0; c < 5; c++) tick();
        reset = 1'b1;
        tick();
        check_reset_state("rst_div");
        reset = 1'b0;
        tick();
        chk("rst_div.in_ready", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_div.no_output", 256'(seen), 256'd0);
        run_vec(1, "rst_div.after");

        // Reset while an output is stalled in EMIT.
        light_dir = tbl[0].ldir;
        out_ready = 1'b0;
        push(1'b1, 256'hD001);
        push(1'b1, 256'hD002);
        wait_valid(lat, 100);
        chk("rst_emit.reached", out_valid, 1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_state("rst_emit");
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("rst_emit.no_output", 256'(seen), 256'd0);
        run_vec(2, "rst_emit.after");
        run_vec(0, "rst_emit.after_hit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
